mem_arbiter16: RTL and testbench
================================

Name: mem_arbiter16

Overview:
- Single-port memory front end placed directly upstream of the 256x16 block RAM wrapper (addra/wea/dina/douta, one-cycle synchronous read).
- Arbitrates the RISC16 instruction-fetch port and the load/store data port onto the one RAM port.
- Sequences the RAM's registered-read latency.
- Returns read data and a one-cycle ack to the winning requester.

Parameters:
ADDR_W, 8, RAM address width (256 words)
DATA_W, 16, RAM/data word width

Ports:
clka  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held until if_ack
if_addr  in  ADDR_W  fetch address; stable while if_req
if_rdata  out  DATA_W  fetched word; valid in if_ack cycle
if_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = store, 0 = load; stable while d_req
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data; valid in d_ack cycle
d_ack  out  1  one-cycle data completion pulse
ram_addra  out  ADDR_W  to RAM addra (registered)
ram_wea  out  1  to RAM wea (registered)
ram_dina  out  DATA_W  to RAM dina (registered)
ram_douta  in  DATA_W  from RAM douta; valid one cycle after address sampled

Behaviour:
- Reset: state IDLE; ram_addra=0, ram_wea=0, ram_dina=0, if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, grant register cleared.
- FSM states:
  - IDLE: no request -> stay. Otherwise grant the winner, register addr/we/wdata into ram_*, set ram_wea = d_we only for a data write, -> ISSUE.
  - ISSUE: RAM samples ram_addra/ram_wea at the end of this cycle; clear ram_wea -> READ.
  - READ: ram_douta valid. Load if_rdata or d_rdata (read) and set the matching ack for the next cycle -> ACK. A write also pulses d_ack; d_rdata is unchanged.
  - ACK: ack high exactly one cycle, no new grant, -> IDLE.
- Latency: req sampled in IDLE at cycle 0 -> ack in cycle 3. Throughput: one access per 4 cycles. Back-to-back requests on the same port are accepted in the IDLE following ACK.
- Arbitration: d_req has fixed priority over if_req when both are high in IDLE. The loser stays pending with no side effects.
- ram_wea is high for exactly one cycle (ISSUE) per store and never during a load or fetch.
- Requester inputs are ignored outside IDLE. Changing addr/data while req is held and not yet acked is a protocol violation; the grant uses values latched in IDLE.
- Address wrap: none. ADDR_W bits are passed straight through; no range checks.
- Request dropped before ack: the access completes anyway and the ack is still pulsed.
- Reset mid-operation: FSM returns to IDLE and acks are suppressed. A store whose ISSUE cycle coincides with rst still commits, because the RAM has no reset.
- rdata registers hold their last value between acks.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both ports request in IDLE, the port not granted last wins. The last-grant flag resets to "fetch", so data wins the first tie.
- Undefined: fixed data-over-fetch priority as above; no last-grant flag.

Decomposition:
- Shared package risc16_mem_pkg holds:
  - ADDR_W/DATA_W constants
  - FSM state encoding (IDLE=2'b00, ISSUE=2'b01, READ=2'b10, ACK=2'b11)
  - grant enum (GNT_IF, GNT_D)
- One natural sub-module, mem_arb_pick: combinational winner select from if_req, d_req and the last-grant flag. Include the last-grant input only under MEM_ARB_RR_EN. The FSM and datapath stay in mem_arbiter16.

Test Plan:
- Store then load, 0x3A: d_req, d_we=1, d_wdata=0xBEEF. Required: ram_wea high one cycle, d_ack at cycle 3. Then a load of 0x3A gives d_rdata=0xBEEF with d_ack at cycle 3.
- Fetch 0x00 after preloading 0x1234: if_rdata=0x1234, if_ack one cycle, ram_wea never asserted.
- Simultaneous if_req (0x10) and d_req load (0x20), fixed priority: data acked first, fetch acked 4 cycles later, each with the correct word. Under MEM_ARB_RR_EN, a second tie grants fetch first.
- Back-to-back fetches 0xFE, 0xFF, 0x00 with if_req held: acks 4 cycles apart, addresses in order, no duplicate grant in the ACK cycle.
- rst asserted during READ of a load: no d_ack, all outputs at reset values next cycle. A later request completes normally.
- rst asserted during ISSUE of a store to 0x05 (0xA5A5): FSM idles, and a subsequent load of 0x05 returns 0xA5A5.

Source files
------------

// File: rtl/risc16_mem_pkg.sv
// Shared types and constants for the RISC16 memory front end.
package risc16_mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        READ  = 2'b10,
        ACK   = 2'b11
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the fetch and data ports.
// Round-robin tie-break when MEM_ARB_RR_EN is defined, data-over-fetch otherwise.
module mem_arb_pick
    import risc16_mem_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
`ifdef MEM_ARB_RR_EN
    input  grant_e last_gnt,
`endif
    output logic   valid,
    output grant_e gnt
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid = if_req | d_req;
        gnt   = GNT_IF;
`ifdef MEM_ARB_RR_EN
        // On a tie, the port that did not win last time goes first.
        if (d_req && (!if_req || last_gnt == GNT_IF))
            gnt = GNT_D;
`else
        if (d_req)
            gnt = GNT_D;
`endif
    end

endmodule

// File: rtl/mem_arbiter16.sv
// Single-port front end for the 256x16 block RAM: arbitrates fetch and data ports,
// sequences the one-cycle registered read. Optional round-robin via MEM_ARB_RR_EN.
module mem_arbiter16 #(
    parameter int ADDR_W = risc16_mem_pkg::ADDR_W,
    parameter int DATA_W = risc16_mem_pkg::DATA_W
) (
    input  logic              clka,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,

    output logic [ADDR_W-1:0] ram_addra,
    output logic              ram_wea,
    output logic [DATA_W-1:0] ram_dina,
    input  logic [DATA_W-1:0] ram_douta
);

    import risc16_mem_pkg::*;

    arb_state_e state;
    grant_e     gnt;
    logic       acc_we;

    logic       pick_valid;
    grant_e     pick_gnt;

    mem_arb_pick u_pick (
        .if_req   (if_req),
        .d_req    (d_req),
`ifdef MEM_ARB_RR_EN
        .last_gnt (gnt),
`endif
        .valid    (pick_valid),
        .gnt      (pick_gnt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clka) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= GNT_IF;
            acc_we    <= 1'b0;
            ram_addra <= '0;
            ram_wea   <= 1'b0;
            ram_dina  <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt <= pick_gnt;
                        if (pick_gnt == GNT_D) begin
                            ram_addra <= d_addr;
                            ram_wea   <= d_we;
                            ram_dina  <= d_wdata;
                            acc_we    <= d_we;
                        end else begin
                            ram_addra <= if_addr;
                            ram_wea   <= 1'b0;
                            acc_we    <= 1'b0;
                        end
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    // The RAM samples address and write enable at the end of this cycle.
                    ram_wea <= 1'b0;
                    state   <= READ;
                end

                READ: begin
                    if (gnt == GNT_D) begin
                        d_ack <= 1'b1;
                        if (!acc_we)
                            d_rdata <= ram_douta;
                    end else begin
                        if_ack   <= 1'b1;
                        if_rdata <= ram_douta;
                    end
                    state <= ACK;
                end

                ACK: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter16.sv
// Self-checking bench for mem_arbiter16: directed table, corner sequences, random mix
// against an ordered-access memory model.
module tb_mem_arbiter16;

    logic        clka = 1'b0;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic [7:0]  ram_addra;
    logic        ram_wea;
    logic [15:0] ram_dina;
    logic [15:0] ram_douta;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clka = ~clka;

    mem_arbiter16 dut (
        .clka      (clka),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .ram_addra (ram_addra),
        .ram_wea   (ram_wea),
        .ram_dina  (ram_dina),
        .ram_douta (ram_douta)
    );

    function automatic logic [15:0] init_word(input int i);
        return 16'(i * 257) ^ 16'h5A5A;
    endfunction

    // Block RAM stand-in: one-cycle registered read, no reset.
    logic        ram_init;
    logic [15:0] ram [256];
    always @(posedge clka) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else begin
            if (ram_wea) ram[ram_addra] <= ram_dina;
            ram_douta <= ram[ram_addra];
        end
    end

    // Reference model: memory contents, last winner, expected held read data.
    logic [15:0] model_mem [256];
    bit          last_d;
    logic [15:0] exp_if_rd;
    logic [15:0] exp_d_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " if_ack"},    32'(if_ack),    0);
        check({tag, " d_ack"},     32'(d_ack),     0);
        check({tag, " ram_addra"}, 32'(ram_addra), 0);
        check({tag, " ram_wea"},   32'(ram_wea),   0);
        check({tag, " ram_dina"},  32'(ram_dina),  0);
        check({tag, " if_rdata"},  32'(if_rdata),  0);
        check({tag, " d_rdata"},   32'(d_rdata),   0);
    endtask

    // One arbitration round from IDLE: either port alone, or both at once.
    // Called on a falling edge with the arbiter idle; returns 16 cycles later.
    task automatic run_txn(input bit use_if, input logic [7:0] ia,
                           input bit use_d, input bit dwe, input logic [7:0] da,
                           input logic [15:0] dwd, input string tag);
        bit         two, first_d;
        int         exp_if_cyc, exp_d_cyc, got_if_cyc, got_d_cyc, n_if, n_d, n_wea;
        logic [7:0] first_addr, second_addr;

        two     = use_if && use_d;
        first_d = use_d && !(use_if && RR_MODE && last_d);

        if (first_d) begin
            if (dwe) model_mem[da] = dwd; else exp_d_rd = model_mem[da];
            last_d = 1'b1;
            if (use_if) begin exp_if_rd = model_mem[ia]; last_d = 1'b0; end
        end else begin
            if (use_if) begin exp_if_rd = model_mem[ia]; last_d = 1'b0; end
            if (use_d) begin
                if (dwe) model_mem[da] = dwd; else exp_d_rd = model_mem[da];
                last_d = 1'b1;
            end
        end
        exp_d_cyc   = (first_d || !two) ? 3 : 7;
        exp_if_cyc  = (!first_d || !two) ? 3 : 7;
        first_addr  = first_d ? da : ia;
        second_addr = first_d ? ia : da;

        if (use_if) begin if_req = 1'b1; if_addr = ia; end
        if (use_d) begin d_req = 1'b1; d_we = dwe; d_addr = da; d_wdata = dwd; end

        got_if_cyc = -1; got_d_cyc = -1; n_if = 0; n_d = 0; n_wea = 0;
        for (int k = 0; k < 16; k++) begin
            if (ram_wea) n_wea++;
            if (k == 1 || k == 3) check({tag, " first addr"}, 32'(ram_addra), 32'(first_addr));
            if (two && k == 5) check({tag, " second addr"}, 32'(ram_addra), 32'(second_addr));
            if (d_ack) begin
                n_d++;
                if (got_d_cyc < 0) got_d_cyc = k;
                d_req = 1'b0;
            end
            if (if_ack) begin
                n_if++;
                if (got_if_cyc < 0) got_if_cyc = k;
                if_req = 1'b0;
            end
            @(negedge clka);
        end

        check({tag, " d_ack count"}, 32'(n_d), use_d ? 1 : 0);
        check({tag, " if_ack count"}, 32'(n_if), use_if ? 1 : 0);
        if (use_d)  check({tag, " d_ack cycle"}, 32'(got_d_cyc), 32'(exp_d_cyc));
        if (use_if) check({tag, " if_ack cycle"}, 32'(got_if_cyc), 32'(exp_if_cyc));
        check({tag, " wea cycles"}, 32'(n_wea), (use_d && dwe) ? 1 : 0);
        check({tag, " if_rdata"}, 32'(if_rdata), 32'(exp_if_rd));
        check({tag, " d_rdata"}, 32'(d_rdata), 32'(exp_d_rd));
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    typedef struct {
        bit          use_if;
        logic [7:0]  ia;
        bit          use_d;
        bit          dwe;
        logic [7:0]  da;
        logic [15:0] dwd;
        logic [15:0] exp_if;
        logic [15:0] exp_d;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [7:0]  bb_addr [3];
        int          bb_cyc [3];
        int          bb_n;
        int          mode;

        vecs[0] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h3A, 16'hBEEF, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3A, 16'h0000, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 16'h1234, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h1234, 16'hBEEF};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 16'h1111, 16'h1234, 16'hBEEF};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 16'h2222, 16'h1234, 16'hBEEF};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFE, 16'hCAFE, 16'h1234, 16'hBEEF};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 16'hF00D, 16'h1234, 16'hBEEF};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 16'h0000, 16'h1234, 16'h1111};

        for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
        last_d = 1'b0; exp_if_rd = '0; exp_d_rd = '0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        rst = 1'b1; ram_init = 1'b1;
        repeat (3) @(negedge clka);
        ram_init = 1'b0;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clka);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].use_if, vecs[i].ia, vecs[i].use_d, vecs[i].dwe,
                    vecs[i].da, vecs[i].dwd, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table if_rdata", i), 32'(if_rdata), 32'(vecs[i].exp_if));
            check($sformatf("vec%0d table d_rdata", i), 32'(d_rdata), 32'(vecs[i].exp_d));
        end

        // Tie after a fetch: data wins in either mode.
        run_txn(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, "pre_tie1");
        run_txn(1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 16'h0000, "tie1");
        check("tie1 d_rdata word", 32'(d_rdata), 32'h2222);
        check("tie1 if_rdata word", 32'(if_rdata), 32'h1111);
        // Tie after a data access: fetch first under round-robin, data first otherwise.
        run_txn(1'b0, 8'h00, 1'b1, 1'b0, 8'h3A, 16'h0000, "pre_tie2");
        run_txn(1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 16'h0000, "tie2");

        // Back-to-back fetches with if_req held across acks.
        bb_addr[0] = 8'hFE; bb_addr[1] = 8'hFF; bb_addr[2] = 8'h00;
        bb_n = 0;
        if_req = 1'b1; if_addr = bb_addr[0];
        for (int k = 0; k < 20; k++) begin
            if (k == 1 || k == 5 || k == 9)
                check($sformatf("b2b addr k%0d", k), 32'(ram_addra), 32'(bb_addr[k / 4]));
            if (if_ack) begin
                if (bb_n < 3) begin
                    bb_cyc[bb_n] = k;
                    check($sformatf("b2b data %0d", bb_n), 32'(if_rdata), 32'(model_mem[bb_addr[bb_n]]));
                end
                bb_n++;
                if (bb_n < 3) if_addr = bb_addr[bb_n]; else if_req = 1'b0;
            end
            @(negedge clka);
        end
        check("b2b ack count", 32'(bb_n), 3);
        if (bb_n >= 3) begin
            check("b2b ack0 cycle", 32'(bb_cyc[0]), 3);
            check("b2b ack1 cycle", 32'(bb_cyc[1]), 7);
            check("b2b ack2 cycle", 32'(bb_cyc[2]), 11);
        end
        if_req = 1'b0;
        exp_if_rd = model_mem[8'h00];
        last_d = 1'b0;

        // Reset during READ of a load: no ack, everything back to reset values.
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h3A;
        @(negedge clka);
        @(negedge clka);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clka);
        check_reset_outputs("rst_in_read");
        rst = 1'b0;
        exp_if_rd = '0; exp_d_rd = '0; last_d = 1'b0;
        @(negedge clka);
        run_txn(1'b0, 8'h00, 1'b1, 1'b0, 8'h3A, 16'h0000, "after_rst_read");

        // Reset during ISSUE of a store: the RAM write still lands.
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h05; d_wdata = 16'hA5A5;
        @(negedge clka);
        check("rst_in_issue wea", 32'(ram_wea), 1);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clka);
        check_reset_outputs("rst_in_issue");
        rst = 1'b0;
        model_mem[8'h05] = 16'hA5A5;
        exp_if_rd = '0; exp_d_rd = '0; last_d = 1'b0;
        @(negedge clka);
        run_txn(1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 16'h0000, "after_rst_issue");

        // Random mix over a narrow address window so ports collide often.
        for (int n = 0; n < 60; n++) begin
            mode = int'($urandom_range(0, 2));
            run_txn(mode != 1, 8'($urandom_range(0, 15)),
                    mode != 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                    16'($urandom), $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
